multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory.
//  Decodes the same opcode set as the single-cycle decoder and issues per-cycle datapath controls.
//  Supports a ready-handshake memory with a bounded wait.
//  Sits between the instruction register (opcode), the ALU (zero flag) and the memory port.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory state waits for mem_ready (1..255); 0 = wait forever
// PORTS
//  clk          in   1  clock, all state updates on rising edge
//  rst          in   1  asynchronous, active-high reset
//  opcode       in   6  instr[31:26] from IR; valid from DECODE onward
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request
//  iord         out  1  memory address select: 0 = PC, 1 = ALUOut
//  mem_write    out  1  store when mem_req & mem_ready
//  ir_write     out  1  load IR
//  pc_en        out  1  PC load = pc_write | (branch & zero)
//  pc_src       out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
//  alu_src_a    out  1  0 = PC, 1 = reg A
//  alu_src_b    out  2  00 = reg B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
//  alu_op       out  2  00 = add, 01 = sub, 10 = funct decode
//  reg_dst      out  1  1 = rd, 0 = rt
//  mem_to_reg   out  1  1 = data register, 0 = ALUOut
//  reg_write    out  1  register file write
//  instr_done   out  1  one-cycle pulse in the last cycle of each instruction
//  illegal_op   out  1  one-cycle pulse in DECODE on an unsupported opcode
//  mem_err      out  1  one-cycle pulse on memory timeout
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  - State register is the only sequential element apart from wait_cnt (8 b).
//  - Outputs are combinational from state. Exceptions: anything qualified by mem_ready, and pc_en.
//  - Any output not listed for a state is 0.
//  - Reset: state = RESET(0), wait_cnt = 0. In RESET every output is 0. RESET -> FETCH unconditionally.
//  - FETCH(1): mem_req, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
//    ir_write = pc_en = mem_ready. On mem_ready -> DECODE.
//  - DECODE(2): alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by opcode:
//    0x23/0x2B -> MEMADR; 0x00 -> EXECUTE; 0x04 -> BRANCH; 0x08 -> ADDIEX; 0x02 -> JUMP.
//    Any other opcode: illegal_op = 1, -> FETCH.
//  - MEMADR(3): alu_src_a = 1, alu_src_b = 10, alu_op = 00. 0x23 -> MEMRD, else -> MEMWR.
//  - MEMRD(4): mem_req, iord = 1. On mem_ready -> MEMWB.
//  - MEMWB(5): reg_write, mem_to_reg = 1, reg_dst = 0, instr_done. -> FETCH.
//  - MEMWR(6): mem_req, iord = 1, mem_write. On mem_ready: instr_done, -> FETCH.
//  - EXECUTE(7): alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> ALUWB.
//  - ALUWB(8): reg_write, reg_dst = 1, instr_done. -> FETCH.
//  - BRANCH(9): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_en = zero, instr_done. -> FETCH.
//  - ADDIEX(10): alu_src_a = 1, alu_src_b = 10, alu_op = 00. -> ADDIWB.
//  - ADDIWB(11): reg_write, reg_dst = 0, mem_to_reg = 0, instr_done. -> FETCH.
//  - JUMP(12): pc_src = 10, pc_en = 1, instr_done. -> FETCH.
//  - Encodings 13-15 are unreachable; they go to FETCH with all outputs 0.
//  - Latency with zero wait: R/ADDI/LW = 4/4/5 cycles, SW = 4, BEQ/J = 3.
//  - wait_cnt is cleared on entry to FETCH/MEMRD/MEMWR.
//    It increments each cycle spent in one of those states with mem_ready = 0.
//  - Timeout fires when MEM_TIMEOUT != 0, wait_cnt == MEM_TIMEOUT-1 and mem_ready = 0.
//    That cycle: mem_err = 1 and next state = FETCH.
//    No ir_write, pc_en, reg_write or instr_done is produced for the aborted access.
//  - mem_ready and the timeout in the same cycle: mem_ready wins, no mem_err.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - rst asserted in any state forces RESET immediately. The access in flight is abandoned.
// TESTING
//  1 rst=1 during MEMRD -> all outputs 0 at once. After release: 1 cycle RESET, then FETCH with mem_req=1.
//  2 opcode=0x00, mem_ready=1 -> states 1,2,7,8. reg_write=1 and reg_dst=1 only in cycle 4, with instr_done.
//  3 opcode=0x23, mem_ready low 3 cycles in MEMRD -> 8 cycles total. MEMWB has mem_to_reg=1, reg_write=1.
//  4 opcode=0x04, zero=1 -> pc_en=1, pc_src=01 in BRANCH. Rerun with zero=0 -> pc_en stays 0.
//  5 MEM_TIMEOUT=4, opcode=0x2B, mem_ready=0 in MEMWR -> mem_req 4 cycles.
//    mem_err pulses in the 4th cycle, no instr_done, next state FETCH.
//  6 opcode=0x3F -> illegal_op pulse in DECODE, then FETCH. No reg_write/mem_write/pc_en.

Source files
------------

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multi-cycle MIPS datapath with a shared ALU and unified memory.
// Issues per-state datapath controls and bounds every memory wait with an optional timeout.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam bit         TIMEOUT_EN   = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_d;
    logic       mem_state;
    logic       timeout;
    logic       op_legal;

    assign state     = state_q;
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // mem_ready has priority: a completing access never times out
    assign timeout   = TIMEOUT_EN && mem_state && !mem_ready && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RESET;
            wait_cnt <= 8'd0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
                else              state_d = S_MEMRD;
            end
            S_MEMWR:   state_d = (mem_ready || timeout) ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Counter runs only while a memory state is stalled; any exit or timeout re-arms it
    always_comb begin
        wait_cnt_d = 8'd0;
        if (mem_state && !mem_ready && !timeout) begin
            wait_cnt_d = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        mem_err    = timeout;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// and compares the state and the packed control word against hand-written vectors.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, mem_err;
    logic [3:0] state;
    logic [17:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    // mreq iord mwr irw pcen pcsrc asa asb aop rdst m2r rw done ill err
    assign ctl = {mem_req, iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, mem_err};

    localparam logic [17:0] C_NONE    = 18'b0_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
    localparam logic [17:0] C_FETCH_W = 18'b1_0_0_0_0_00_0_01_00_0_0_0_0_0_0;
    localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_1_00_0_01_00_0_0_0_0_0_0;
    localparam logic [17:0] C_FETCH_T = 18'b1_0_0_0_0_00_0_01_00_0_0_0_0_0_1;
    localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_00_0_11_00_0_0_0_0_0_0;
    localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_00_0_11_00_0_0_0_0_1_0;
    localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_00_1_10_00_0_0_0_0_0_0;
    localparam logic [17:0] C_MEMRD   = 18'b1_1_0_0_0_00_0_00_00_0_0_0_0_0_0;
    localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_00_0_00_00_0_1_1_1_0_0;
    localparam logic [17:0] C_MEMWR_W = 18'b1_1_1_0_0_00_0_00_00_0_0_0_0_0_0;
    localparam logic [17:0] C_MEMWR_R = 18'b1_1_1_0_0_00_0_00_00_0_0_0_1_0_0;
    localparam logic [17:0] C_MEMWR_T = 18'b1_1_1_0_0_00_0_00_00_0_0_0_0_0_1;
    localparam logic [17:0] C_EXECUTE = 18'b0_0_0_0_0_00_1_00_10_0_0_0_0_0_0;
    localparam logic [17:0] C_ALUWB   = 18'b0_0_0_0_0_00_0_00_00_1_0_1_1_0_0;
    localparam logic [17:0] C_BR_TAKE = 18'b0_0_0_0_1_01_1_00_01_0_0_0_1_0_0;
    localparam logic [17:0] C_BR_NOT  = 18'b0_0_0_0_0_01_1_00_01_0_0_0_1_0_0;
    localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_00_0_00_00_0_0_1_1_0_0;
    localparam logic [17:0] C_JUMP    = 18'b0_0_0_0_1_10_0_00_00_0_0_0_1_0_0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already applied; checks, then advances a cycle.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] ex);
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_ctl"}, 32'(ctl), 32'(ex));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        cyc("reset_hold", 4'd0, C_NONE);
        rst = 1'b0;
        cyc("reset_exit", 4'd0, C_NONE);

        // R-type with zero-wait memory
        mem_ready = 1'b1; opcode = 6'h00;
        cyc("r_fetch", 4'd1, C_FETCH_R);
        cyc("r_decode", 4'd2, C_DECODE);
        cyc("r_exec", 4'd7, C_EXECUTE);
        cyc("r_wb", 4'd8, C_ALUWB);

        // LW with three stalled cycles in MEMRD: 8 cycles total
        opcode = 6'h23;
        cyc("lw_fetch", 4'd1, C_FETCH_R);
        cyc("lw_decode", 4'd2, C_DECODE);
        cyc("lw_adr", 4'd3, C_MEMADR);
        mem_ready = 1'b0;
        cyc("lw_rd_w0", 4'd4, C_MEMRD);
        cyc("lw_rd_w1", 4'd4, C_MEMRD);
        cyc("lw_rd_w2", 4'd4, C_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_rd_ok", 4'd4, C_MEMRD);
        cyc("lw_wb", 4'd5, C_MEMWB);

        // BEQ taken then not taken
        opcode = 6'h04; zero = 1'b1;
        cyc("beq1_fetch", 4'd1, C_FETCH_R);
        cyc("beq1_decode", 4'd2, C_DECODE);
        cyc("beq1_br", 4'd9, C_BR_TAKE);
        zero = 1'b0;
        cyc("beq0_fetch", 4'd1, C_FETCH_R);
        cyc("beq0_decode", 4'd2, C_DECODE);
        cyc("beq0_br", 4'd9, C_BR_NOT);

        // Jump and ADDI
        opcode = 6'h02;
        cyc("j_fetch", 4'd1, C_FETCH_R);
        cyc("j_decode", 4'd2, C_DECODE);
        cyc("j_jump", 4'd12, C_JUMP);
        opcode = 6'h08;
        cyc("addi_fetch", 4'd1, C_FETCH_R);
        cyc("addi_decode", 4'd2, C_DECODE);
        cyc("addi_ex", 4'd10, C_MEMADR);
        cyc("addi_wb", 4'd11, C_ADDIWB);

        // SW completing immediately
        opcode = 6'h2B;
        cyc("sw_fetch", 4'd1, C_FETCH_R);
        cyc("sw_decode", 4'd2, C_DECODE);
        cyc("sw_adr", 4'd3, C_MEMADR);
        cyc("sw_wr_ok", 4'd6, C_MEMWR_R);

        // SW timing out after 4 cycles of mem_req
        cyc("swto_fetch", 4'd1, C_FETCH_R);
        cyc("swto_decode", 4'd2, C_DECODE);
        cyc("swto_adr", 4'd3, C_MEMADR);
        mem_ready = 1'b0;
        cyc("swto_w0", 4'd6, C_MEMWR_W);
        cyc("swto_w1", 4'd6, C_MEMWR_W);
        cyc("swto_w2", 4'd6, C_MEMWR_W);
        cyc("swto_err", 4'd6, C_MEMWR_T);

        // Fetch times out and restarts itself with a fresh count
        cyc("fto_w0", 4'd1, C_FETCH_W);
        cyc("fto_w1", 4'd1, C_FETCH_W);
        cyc("fto_w2", 4'd1, C_FETCH_W);
        cyc("fto_err", 4'd1, C_FETCH_T);
        // mem_ready on the would-be timeout cycle wins
        cyc("fbnd_w0", 4'd1, C_FETCH_W);
        cyc("fbnd_w1", 4'd1, C_FETCH_W);
        cyc("fbnd_w2", 4'd1, C_FETCH_W);
        mem_ready = 1'b1; opcode = 6'h3F;
        cyc("fbnd_ok", 4'd1, C_FETCH_R);

        // Illegal opcode
        cyc("ill_decode", 4'd2, C_DEC_ILL);
        opcode = 6'h23;
        cyc("ill_back", 4'd1, C_FETCH_R);

        // Asynchronous reset during a stalled MEMRD
        cyc("rmid_decode", 4'd2, C_DECODE);
        cyc("rmid_adr", 4'd3, C_MEMADR);
        mem_ready = 1'b0;
        cyc("rmid_rd", 4'd4, C_MEMRD);
        rst = 1'b1;
        #1;
        check("rmid_async_state", 32'(state), 32'd0);
        check("rmid_async_ctl", 32'(ctl), 32'(C_NONE));
        @(negedge clk);
        rst = 1'b0;
        cyc("rmid_reset", 4'd0, C_NONE);
        cyc("rmid_fetch", 4'd1, C_FETCH_W);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
